// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter slice.
// Contents: FSM state encoding, default baud divider for a 50 MHz clock at
// 9600 bps, and a helper that returns the frame length in bit periods.
package uart_pkg;

  // Transmitter FSM states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int unsigned SYS_CLK_HZ      = 50_000_000;
  localparam int unsigned BAUD_RATE       = 9_600;
  localparam int unsigned CLK_DIV_DEFAULT = SYS_CLK_HZ / BAUD_RATE;

  // Bit periods in one frame: start + data + optional parity + stop bits
  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned stop_bits,
                                             input bit          parity_en);
    return 1 + data_bits + (parity_en ? 1 : 0) + stop_bits;
  endfunction

endpackage : uart_pkg

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART transmitter.
// Counts 0..CLK_DIV-1 and wraps; bit_end is high during the last count of
// each bit period. restart holds the count at zero.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   restart  synchronous clear, held while the transmitter is idle
//   cnt      current position inside the bit period
//   bit_end  one-cycle pulse on the final cycle of a bit period
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter  int unsigned CLK_DIV = CLK_DIV_DEFAULT,
  localparam int unsigned CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  output logic [CNT_W-1:0] cnt,
  output logic             bit_end
);

  // Counter with wrap at CLK_DIV-1; bit_end is registered one cycle early
  // so it lines up with cnt == CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt     <= '0;
      bit_end <= 1'b0;
    end else begin
      if (cnt == CNT_W'(CLK_DIV - 1)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      bit_end <= (cnt == CNT_W'(CLK_DIV - 2));
    end
  end

endmodule : uart_baud_gen

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with built-in baud divider.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits. Back-to-back frames run without an idle gap when a
// new word is accepted in the last cycle of the last stop bit.
// Optional parity is enabled by defining UART_TX_PARITY_EN; PARITY_ODD
// selects odd (1) or even (0) parity and is otherwise ignored.
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset, aborts any frame
//   tx_valid  a word is offered on tx_data
//   tx_data   word to transmit, latched on acceptance
//   tx_ready  transmitter accepts a word this cycle
//   tx_busy   a frame is in progress
//   txd       serial line, idle high
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = CLK_DIV_DEFAULT,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 txd
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  // Elaboration-time parameter legality checks
  if (CLK_DIV < 2) begin : g_chk_div
    $error("uart_tx_param: CLK_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD > 1) begin : g_chk_par
    $error("uart_tx_param: PARITY_ODD must be 0 or 1");
  end

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [CNT_W-1:0]     baud_cnt;
  logic                 bit_end;
  logic                 baud_restart;
  logic                 accept;
  logic                 last_data;
  logic                 last_stop;
  logic                 txd_nxt;
  logic                 ready_nxt;
  logic                 busy_nxt;
`ifdef UART_TX_PARITY_EN
  logic                 parity, parity_nxt;
`endif

  // Bit timer is held at zero while idle so each frame starts on a fresh period
  assign baud_restart = (state == IDLE);

  uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (baud_restart),
    .cnt     (baud_cnt),
    .bit_end (bit_end)
  );

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      txd      <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      txd      <= txd_nxt;
      tx_ready <= ready_nxt;
      tx_busy  <= busy_nxt;
`ifdef UART_TX_PARITY_EN
      parity   <= parity_nxt;
`endif
    end
  end

  // Next-state, datapath and next-output logic
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    txd_nxt     = 1'b1;
    ready_nxt   = 1'b0;
    busy_nxt    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_nxt  = parity;
`endif

    // tx_ready is only ever high in IDLE or the final stop cycle
    accept    = tx_valid && tx_ready;
    last_data = (bit_cnt == BIT_W'(DATA_BITS - 1));
    last_stop = (bit_cnt == BIT_W'(STOP_BITS - 1));

    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt   = START;
          shreg_nxt   = tx_data;
          bit_cnt_nxt = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_nxt = shreg >> 1;
          if (last_data) begin
            bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
            state_nxt   = PARITY;
`else
            state_nxt   = STOP;
`endif
          end else begin
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_nxt   = STOP;
          bit_cnt_nxt = '0;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          bit_cnt_nxt = '0;
          if (!last_stop) begin
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
          end else if (accept) begin
            // Back-to-back: straight into the next start bit
            state_nxt = START;
            shreg_nxt = tx_data;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt   = IDLE;
        bit_cnt_nxt = '0;
      end
    endcase

`ifdef UART_TX_PARITY_EN
    if (accept) begin
      parity_nxt = (^tx_data) ^ 1'(PARITY_ODD);
    end
`endif

    // Line level for the coming cycle follows the next state
    case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_nxt = parity_nxt;
`endif
      default: txd_nxt = 1'b1;
    endcase

    busy_nxt  = (state_nxt != IDLE);
    // Ready next cycle if idle, or if next cycle is the last cycle of the last stop bit
    ready_nxt = (state_nxt == IDLE) ||
                ((state == STOP) && last_stop && (baud_cnt == CNT_W'(CLK_DIV - 2)));
  end

endmodule : uart_tx_param
